// File: rtl/fb_addr_dblbuf.sv
// Purpose : double-buffered framebuffer address controller; CPU-requested FRONT/BACK swap lands on vsync rise.
// Latency : reads zero-wait combinational; swap/frame count SYNC_STAGES+1 clk after vsync rise; irq 1 clk after done.
// Backpr. : none; Avalon slave is always ready, extra swap requests while armed are dropped (swaps never queue).
//
// Ports:
//   clk, reset_n            system clock, asynchronous active-low reset
//   address/chipselect/     Avalon-MM slave (3-bit word address, active-low write strobe)
//   write_n/writedata/readdata
//   vsync                   vertical sync, asynchronous to clk, active high
//   front_addr, back_addr   registered scan-out / render-target base addresses
//   irq                     level swap-done interrupt
//
// Register map: 0 FRONT(RO) 1 BACK(RW) 2 CTRL{irq_en,swap_req} 3 STATUS{done(W1C),pending} 4 FRAME_CNT(RO)
// Optional feature: define FB_ADDR_DBLBUF_IRQ_EN to build the IRQ_EN bit and irq output;
// otherwise irq is tied 0, CTRL bit1 reads 0, and done remains available for polling.

module fb_addr_dblbuf #(
    parameter int              ADDR_W      = 24,
    parameter int              CNT_W       = 16,
    parameter int              SYNC_STAGES = 2,
    parameter logic [ADDR_W-1:0] RESET_FRONT = '0,
    parameter logic [ADDR_W-1:0] RESET_BACK  = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [2:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    input  logic              vsync,
    output logic [ADDR_W-1:0] front_addr,
    output logic [ADDR_W-1:0] back_addr,
    output logic              irq
);

    typedef enum logic {IDLE = 1'b0, ARMED = 1'b1} state_t;

    state_t                 state_q, state_d;
    logic [ADDR_W-1:0]      front_q, back_q;
    logic [CNT_W-1:0]       frame_cnt_q;
    logic                   done_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   edge_q;
    logic                   vs_rise;
    logic                   pending;
    logic                   swap_fire;

    // Bus decode
    logic wr, back_wr, ctrl_wr, status_wr, swap_wr, done_clr;
    assign wr        = chipselect & ~write_n;
    assign back_wr   = wr & (address == 3'd1);
    assign ctrl_wr   = wr & (address == 3'd2);
    assign status_wr = wr & (address == 3'd3);
    assign swap_wr   = ctrl_wr & writedata[0];
    assign done_clr  = status_wr & writedata[1];

    // Upper writedata bits only feed the BACK register when ADDR_W is wide enough.
    logic unused_wdata;
    assign unused_wdata = ^writedata;

    // vsync synchroniser plus edge flop; vs_rise is a one-cycle pulse per vsync rise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], vsync};
            edge_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign vs_rise = sync_q[SYNC_STAGES-1] & ~edge_q;

    // Swap FSM: state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Swap FSM: next state. A request landing on a vs_rise while idle only arms;
    // the swap waits for the following frame.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (swap_wr) state_d = ARMED;
            ARMED:   if (vs_rise) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Swap FSM: outputs
    always_comb begin
        pending   = 1'b0;
        swap_fire = 1'b0;
        case (state_q)
            IDLE:    pending = 1'b0;
            ARMED: begin
                pending   = 1'b1;
                swap_fire = vs_rise;
            end
            default: pending = 1'b0;
        endcase
    end

    // Address registers. A CPU BACK write coinciding with a swap wins over the
    // swapped-in old FRONT; FRONT still takes the pre-write BACK.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            front_q <= RESET_FRONT;
            back_q  <= RESET_BACK;
        end else begin
            if (swap_fire) begin
                front_q <= back_q;
            end
            if (back_wr) begin
                back_q <= writedata[ADDR_W-1:0];
            end else if (swap_fire) begin
                back_q <= front_q;
            end
        end
    end

    // done: set by a swap, cleared by write-1; set wins on collision.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done_q <= 1'b0;
        end else if (swap_fire) begin
            done_q <= 1'b1;
        end else if (done_clr) begin
            done_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt_q <= '0;
        end else if (vs_rise) begin
            frame_cnt_q <= frame_cnt_q + CNT_W'(1);
        end
    end

`ifdef FB_ADDR_DBLBUF_IRQ_EN
    logic irq_en_q;
    logic irq_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                irq_en_q <= writedata[1];
            end
            irq_q <= done_q & irq_en_q;
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    // Zero-wait read mux; unused bits read 0.
    always_comb begin
        readdata = '0;
        case (address)
            3'd0: readdata[ADDR_W-1:0] = front_q;
            3'd1: readdata[ADDR_W-1:0] = back_q;
            3'd2: begin
                readdata[0] = pending;
`ifdef FB_ADDR_DBLBUF_IRQ_EN
                readdata[1] = irq_en_q;
`endif
            end
            3'd3: begin
                readdata[0] = pending;
                readdata[1] = done_q;
            end
            3'd4: readdata[CNT_W-1:0] = frame_cnt_q;
            default: readdata = '0;
        endcase
    end

    assign front_addr = front_q;
    assign back_addr  = back_q;

endmodule
